// File: rtl/risc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// risc_seq_ctrl
//   Phase-sequencing controller for the basic RISC datapath. Walks an 8-phase
//   fetch/execute cycle and decodes the IR opcode into datapath strobes.
//   sel_o drives the address mux in front of memory: 1 = PC, 0 = IR address.
//
//   Optional build macro: SINGLE_STEP_EN
//     defined   : adds step_i; the controller waits in phase 0 until step_i is
//                 sampled high on a clock edge, then runs a whole instruction.
//     undefined : no step_i port; phase 0 lasts exactly one cycle.
//
// Parameters
//   STALL_CYCLES  extra wait cycles in INST_FETCH and OP_FETCH (legal 0..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode_i   in   IR[7:5]: 0 HLT,1 SKZ,2 ADD,3 AND,4 XOR,5 LDA,6 STO,7 JMP
//   zero_i     in   accumulator == 0 flag
//   step_i     in   single-step advance (SINGLE_STEP_EN builds only)
//   sel_o      out  address mux select (1 = PC, 0 = IR address)
//   rd_o       out  memory read enable
//   wr_o       out  memory write strobe
//   ld_ir_o    out  load instruction register
//   ld_ac_o    out  load accumulator
//   ld_pc_o    out  load PC from IR address
//   inc_pc_o   out  increment PC
//   data_e_o   out  drive accumulator onto the data bus
//   halt_o     out  processor halted
//   phase_o    out  current phase index (debug)
// -----------------------------------------------------------------------------
module risc_seq_ctrl #(
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode_i,
  input  logic       zero_i,
`ifdef SINGLE_STEP_EN
  input  logic       step_i,
`endif
  output logic       sel_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic       ld_ir_o,
  output logic       ld_ac_o,
  output logic       ld_pc_o,
  output logic       inc_pc_o,
  output logic       data_e_o,
  output logic       halt_o,
  output logic [2:0] phase_o
);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Reload value for the stall counter on entry to a fetch phase.
  localparam logic [3:0] STALL_LD = STALL_CYCLES[3:0];

  logic [2:0] phase_q, phase_d;
  logic [3:0] stall_q, stall_d;
  logic       halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, alu_op;
  logic advance_ph0;

  // Opcode decode. A case statement lets an unknown opcode fall to the
  // default arm, so nothing matches and no X reaches the strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_sto = 1'b0;
    is_jmp = 1'b0;
    alu_op = 1'b0;
    case (opcode_i)
      OP_HLT: is_hlt = 1'b1;
      OP_SKZ: is_skz = 1'b1;
      OP_ADD, OP_AND, OP_XOR, OP_LDA: alu_op = 1'b1;
      OP_STO: is_sto = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

`ifdef SINGLE_STEP_EN
  assign advance_ph0 = step_i;
`else
  assign advance_ph0 = 1'b1;
`endif

  // Next-state logic.
  always_comb begin
    phase_d  = phase_q;
    stall_d  = stall_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (phase_q)
        PH_INST_ADDR: begin
          if (advance_ph0) begin
            phase_d = PH_INST_FETCH;
            stall_d = STALL_LD;
          end
        end
        PH_INST_FETCH, PH_OP_FETCH: begin
          // Hold the fetch phase until the stall counter has run out.
          if (stall_q != 4'd0) stall_d = stall_q - 4'd1;
          else                 phase_d = phase_q + 3'd1;
        end
        PH_OP_ADDR: begin
          // A halt freezes the phase at OP_ADDR until reset.
          if (is_hlt) begin
            halted_d = 1'b1;
          end else begin
            phase_d = PH_OP_FETCH;
            stall_d = STALL_LD;
          end
        end
        default: phase_d = phase_q + 3'd1;  // STORE wraps to INST_ADDR
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_INST_ADDR;
      stall_q  <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      phase_q  <= phase_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
    end
  end

  // Output decode: purely from registered state plus the current opcode and
  // zero flag, so the reset values appear as soon as rst_n falls.
  always_comb begin
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    wr_o     = 1'b0;
    ld_ir_o  = 1'b0;
    ld_ac_o  = 1'b0;
    ld_pc_o  = 1'b0;
    inc_pc_o = 1'b0;
    data_e_o = 1'b0;
    halt_o   = 1'b0;
    if (halted_q) begin
      halt_o = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: sel_o = 1'b1;
        PH_INST_FETCH: begin
          sel_o = 1'b1;
          rd_o  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel_o   = 1'b1;
          rd_o    = 1'b1;
          ld_ir_o = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc_o = 1'b1;
          halt_o   = is_hlt;
        end
        PH_OP_FETCH: rd_o = alu_op;
        PH_ALU_OP: begin
          rd_o     = alu_op;
          ld_pc_o  = is_jmp;
          data_e_o = is_sto;
          if (is_skz && zero_i) inc_pc_o = 1'b1;
        end
        default: begin  // PH_STORE
          rd_o     = alu_op;
          ld_ac_o  = alu_op;
          ld_pc_o  = is_jmp;
          wr_o     = is_sto;
          data_e_o = is_sto;
        end
      endcase
    end
  end

  assign phase_o = phase_q;

endmodule
